// File: rtl/atcdmac300_chsched_pkg.sv
// Shared constants for the DMA channel scheduler: channel count, index width
// and the scheduler FSM encoding.
package atcdmac300_chsched_pkg;

    localparam int unsigned CH_COUNT = 8;
    localparam int unsigned CH_IDX_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARB   = 2'd1,
        ST_ISSUE = 2'd2,
        ST_WAIT  = 2'd3
    } sched_state_e;

endpackage

// File: rtl/atcdmac300_arbiter.sv
// Two-level round-robin channel arbiter: high-level requests beat low-level ones,
// and within a level the search starts at current_channel+1 and wraps.
module atcdmac300_arbiter
    import atcdmac300_chsched_pkg::*;
(
    input  logic [CH_COUNT-1:0] ch_request,
    input  logic [CH_COUNT-1:0] ch_level,
    input  logic [CH_IDX_W-1:0] current_channel,
    output logic [CH_IDX_W-1:0] granted_channel
);

    logic                hi_found;
    logic                lo_found;
    logic [CH_IDX_W-1:0] hi_ch;
    logic [CH_IDX_W-1:0] lo_ch;
    logic [CH_IDX_W-1:0] idx;

    // Offset CH_COUNT wraps back to current_channel itself, so it is searched last.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_ch    = '0;
        lo_ch    = '0;
        idx      = '0;
        for (int unsigned k = 1; k <= CH_COUNT; k++) begin
            idx = current_channel + CH_IDX_W'(k);
            if (ch_request[idx]) begin
                if (ch_level[idx] && !hi_found) begin
                    hi_found = 1'b1;
                    hi_ch    = idx;
                end
                if (!ch_level[idx] && !lo_found) begin
                    lo_found = 1'b1;
                    lo_ch    = idx;
                end
            end
        end
        granted_channel = hi_found ? hi_ch : lo_ch;
    end

endmodule

// File: rtl/atcdmac300_chsched.sv
// DMA channel scheduler: arbitrates channel requests, issues the winner to the
// data engine over valid/ready and holds until the engine reports the burst done.
module atcdmac300_chsched
    import atcdmac300_chsched_pkg::*;
#(
    parameter int unsigned CH_NUM = CH_COUNT
) (
    input  logic                hclk,
    input  logic                hreset,
    input  logic                dma_en,
    input  logic [CH_NUM-1:0]   ch_en,
    input  logic [CH_NUM-1:0]   ch_pending,
    input  logic [CH_NUM-1:0]   ch_level,
    input  logic [CH_NUM-1:0]   ch_abort,
    input  logic                eng_ready,
    input  logic                eng_done,
    output logic                eng_valid,
    output logic [CH_IDX_W-1:0] eng_ch,
    output logic [CH_IDX_W-1:0] current_channel,
    output logic                busy
);

    sched_state_e        state;
    sched_state_e        state_next;
    logic [CH_NUM-1:0]   req;
    logic                any_req;
    logic                withdraw;
    logic                load_grant;
    logic                accept;
    logic [CH_IDX_W-1:0] grant_ch;
    logic [CH_IDX_W-1:0] granted_channel;

    assign req      = dma_en ? (ch_en & ch_pending & ~ch_abort) : '0;
    assign any_req  = |req;
    assign withdraw = ch_abort[grant_ch] || !ch_en[grant_ch];

    atcdmac300_arbiter u_arbiter (
        .ch_request      (req),
        .ch_level        (ch_level),
        .current_channel (current_channel),
        .granted_channel (granted_channel)
    );

    // Next-state decode; a handshake in ISSUE wins over a same-cycle withdraw.
    always_comb begin
        state_next = state;
        load_grant = 1'b0;
        accept     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (any_req) state_next = ST_ARB;
            end
            ST_ARB: begin
                if (any_req) begin
                    load_grant = 1'b1;
                    state_next = ST_ISSUE;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (eng_ready) begin
                    accept     = 1'b1;
                    state_next = ST_WAIT;
                end else if (withdraw) begin
                    state_next = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (eng_done) state_next = any_req ? ST_ARB : ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state           <= ST_IDLE;
            grant_ch        <= '0;
            eng_valid       <= 1'b0;
            eng_ch          <= '0;
            current_channel <= '0;
            busy            <= 1'b0;
        end else begin
            state     <= state_next;
            eng_valid <= (state_next == ST_ISSUE);
            busy      <= (state_next != ST_IDLE);
            if (load_grant) begin
                grant_ch <= granted_channel;
                eng_ch   <= granted_channel;
            end
            if (accept) current_channel <= grant_ch;
        end
    end

endmodule

// File: tb/tb_atcdmac300_chsched.sv
// Scoreboard bench for the channel scheduler: the driver pushes the channel the
// reference model expects, the monitor pops and compares at every handshake.
module tb_atcdmac300_chsched;

    logic       hclk = 1'b0;
    logic       hreset;
    logic       dma_en;
    logic [7:0] ch_en;
    logic [7:0] ch_pending;
    logic [7:0] ch_level;
    logic [7:0] ch_abort;
    logic       eng_ready;
    logic       eng_done;
    logic       eng_valid;
    logic [2:0] eng_ch;
    logic [2:0] current_channel;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    logic [2:0] exp_q[$];
    logic [2:0] mcur;

    logic [2:0] cur_exp;
    bit         cur_chk  = 0;
    logic       prev_valid = 1'b0;
    logic [2:0] prev_ch  = '0;
    logic       prev_hs  = 1'b0;

    atcdmac300_chsched dut (
        .hclk            (hclk),
        .hreset          (hreset),
        .dma_en          (dma_en),
        .ch_en           (ch_en),
        .ch_pending      (ch_pending),
        .ch_level        (ch_level),
        .ch_abort        (ch_abort),
        .eng_ready       (eng_ready),
        .eng_done        (eng_done),
        .eng_valid       (eng_valid),
        .eng_ch          (eng_ch),
        .current_channel (current_channel),
        .busy            (busy)
    );

    always #5 hclk = ~hclk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: smallest key wins; key = level class (high=0, low=8) plus the
    // rotational distance from the channel after the last accepted one.
    function automatic logic [2:0] model_pick(input logic [7:0] r, input logic [7:0] l,
                                              input logic [2:0] cur);
        int best = 0;
        int best_key = 1000;
        int key;
        for (int c = 0; c < 8; c++) begin
            if (r[c]) begin
                key = (l[c] ? 0 : 8) + ((c - int'(cur) - 1 + 16) % 8);
                if (key < best_key) begin
                    best_key = key;
                    best = c;
                end
            end
        end
        return 3'(best);
    endfunction

    // Monitor: compares issued channels and the following current_channel update.
    always @(negedge hclk) begin
        logic [2:0] e;
        if (cur_chk) begin
            check("current_after_hs", int'(current_channel), int'(cur_exp));
            cur_chk = 0;
        end
        if (!hreset && prev_valid && eng_valid && !prev_hs)
            check("eng_ch_hold", int'(eng_ch), int'(prev_ch));
        if (!hreset && eng_valid && eng_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_issue actual_ch=%0d expected=none t=%0t", eng_ch, $time);
            end else begin
                e = exp_q.pop_front();
                check("issued_ch", int'(eng_ch), int'(e));
                cur_exp = e;
                cur_chk = 1;
            end
        end
        prev_valid = eng_valid;
        prev_ch    = eng_ch;
        prev_hs    = eng_valid && eng_ready;
    end

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!eng_valid && n < 40) begin
            tick();
            n++;
        end
        check("valid_within_bound", int'(eng_valid), 1);
    endtask

    task automatic issue_and_ack(input int rd);
        wait_valid();
        repeat (rd) tick();
        eng_ready = 1'b1;
        tick();
        eng_ready = 1'b0;
    endtask

    task automatic finish_burst(input int dd, input logic [7:0] new_pending);
        repeat (dd) tick();
        eng_done   = 1'b1;
        ch_pending = new_pending;
        tick();
        eng_done = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog_timeout actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] en, pend, lvl, r;
        logic       d;
        logic [2:0] e;

        hreset = 1'b1; dma_en = 1'b0; ch_en = '0; ch_pending = '0; ch_level = '0;
        ch_abort = '0; eng_ready = 1'b0; eng_done = 1'b0; mcur = '0;
        repeat (3) @(posedge hclk);
        #1;
        check("rst_valid", int'(eng_valid), 0);
        check("rst_eng_ch", int'(eng_ch), 0);
        check("rst_current", int'(current_channel), 0);
        check("rst_busy", int'(busy), 0);
        hreset = 1'b0;
        dma_en = 1'b1;
        repeat (6) begin
            tick();
            check("idle_valid", int'(eng_valid), 0);
            check("idle_busy", int'(busy), 0);
            check("idle_current", int'(current_channel), 0);
        end

        // Round robin over ch1, ch2, ch5 from current_channel=0
        ch_en = 8'hFF; ch_level = 8'h00; ch_pending = 8'b0010_0110;
        exp_q.push_back(3'd1); exp_q.push_back(3'd2);
        exp_q.push_back(3'd5); exp_q.push_back(3'd1);
        repeat (3) begin
            issue_and_ack(0);
            finish_burst(3, 8'b0010_0110);
        end
        issue_and_ack(0);
        finish_burst(3, 8'h00);
        mcur = 3'd1;
        tick();
        check("rr_current", int'(current_channel), 1);
        check("rr_busy", int'(busy), 0);

        // Single request: latency from IDLE
        ch_pending = 8'h08; eng_ready = 1'b1;
        exp_q.push_back(3'd3);
        tick();
        check("lat_c1_valid", int'(eng_valid), 0);
        check("lat_c1_busy", int'(busy), 1);
        tick();
        check("lat_c2_valid", int'(eng_valid), 1);
        check("lat_c2_ch", int'(eng_ch), 3);
        tick();
        eng_ready = 1'b0;
        check("wait_valid_low", int'(eng_valid), 0);
        finish_burst(2, 8'h00);
        mcur = 3'd3;
        check("single_current", int'(current_channel), 3);
        check("single_busy", int'(busy), 0);

        // Priority: ch6 high beats ch1 low until ch6 stops pending
        ch_level = 8'h40; ch_pending = 8'h42;
        repeat (3) exp_q.push_back(3'd6);
        exp_q.push_back(3'd1);
        issue_and_ack(1);
        finish_burst(1, 8'h42);
        issue_and_ack(2);
        finish_burst(0, 8'h42);
        issue_and_ack(0);
        finish_burst(2, 8'h02);
        issue_and_ack(0);
        finish_burst(1, 8'h00);
        mcur = 3'd1;
        check("prio_current", int'(current_channel), 1);

        // Stall then abort: withdraw leaves current_channel alone
        ch_level = 8'h00; ch_pending = 8'h10;
        wait_valid();
        repeat (5) begin
            check("stall_valid", int'(eng_valid), 1);
            check("stall_ch", int'(eng_ch), 4);
            tick();
        end
        ch_abort = 8'h10;
        tick();
        ch_abort = 8'h00;
        check("abort_valid", int'(eng_valid), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_current", int'(current_channel), int'(mcur));

        // Abort and ready together: handshake wins
        exp_q.push_back(3'd4);
        wait_valid();
        ch_abort = 8'h10; eng_ready = 1'b1;
        tick();
        ch_abort = 8'h00; eng_ready = 1'b0;
        check("abort_hs_busy", int'(busy), 1);
        check("abort_hs_valid", int'(eng_valid), 0);
        finish_burst(1, 8'h00);
        mcur = 3'd4;

        // Disabling the granted channel also withdraws
        ch_pending = 8'h01;
        wait_valid();
        ch_en = 8'hFE;
        tick();
        check("disable_valid", int'(eng_valid), 0);
        check("disable_busy", int'(busy), 0);
        ch_en = 8'hFF; ch_pending = 8'h00;
        repeat (3) tick();
        check("disable_current", int'(current_channel), int'(mcur));

        // Randomized traffic against the reference model
        repeat (60) begin
            en   = 8'($urandom);
            pend = 8'($urandom);
            lvl  = 8'($urandom);
            d    = ($urandom_range(0, 4) != 0);
            ch_en = en; ch_pending = pend; ch_level = lvl; dma_en = d;
            r = d ? (en & pend) : 8'h00;
            if (r != 8'h00) begin
                e = model_pick(r, lvl, mcur);
                exp_q.push_back(e);
                mcur = e;
                issue_and_ack($urandom_range(0, 3));
                finish_burst($urandom_range(0, 3), pend);
            end else begin
                repeat (3) tick();
                check("rand_no_issue", int'(eng_valid), 0);
            end
        end
        ch_pending = 8'h00; ch_en = 8'hFF; dma_en = 1'b1;
        repeat (4) tick();
        check("rand_settle_busy", int'(busy), 0);

        // Asynchronous reset while in WAIT
        ch_level = 8'h00; ch_pending = 8'h04;
        e = model_pick(8'h04, 8'h00, mcur);
        exp_q.push_back(e);
        issue_and_ack(0);
        mcur = e;
        ch_pending = 8'h00;
        repeat (2) tick();
        check("pre_reset_busy", int'(busy), 1);
        #2 hreset = 1'b1;
        #1;
        check("arst_valid", int'(eng_valid), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_current", int'(current_channel), 0);
        check("arst_eng_ch", int'(eng_ch), 0);
        #2 hreset = 1'b0;
        tick();
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        repeat (3) begin
            tick();
            check("post_rst_busy", int'(busy), 0);
            check("post_rst_valid", int'(eng_valid), 0);
        end

        check("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
